// File: rtl/std_skid_buf.sv
// Two-entry valid/ready pipeline stage: a main register feeds the output,
// and a skid register catches the one item that arrives while the consumer stalls.
module std_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             pop;

  // in_ready looks only at local state (and reset), never at out_ready.
  assign in_ready  = (state_q != FULL) & rstn;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // Payload registers are left alone; they are meaningless once invalid.
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (pop) begin
            state_q <= EMPTY;
          end else if (acc) begin
            skid_q  <= in_data;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
